// File: rtl/sensor_conditioner.sv
// Track-sensor front end: two-flop synchronisers, per-channel debounce,
// rising-edge pulses and a sticky stuck-active fault flag for supervision.
module sensor_conditioner #(
  parameter int DEB_CYCLES   = 4,
  parameter int DEB_W        = 3,
  parameter int STUCK_CYCLES = 1000,
  parameter int STUCK_W      = 10
) (
  input  logic       Clock,
  input  logic       RESET,
  input  logic [4:1] RAW,
  input  logic       FAULT_CLR,
  output logic [4:1] SR,
  output logic [4:1] SR_RISE,
  output logic [4:1] FAULT
);

  localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

  logic [4:1]         s1_q, s2_q;
  logic [4:1]         sr_q, sr_d;
  logic [4:1]         rise_q, rise_d;
  logic [4:1]         fault_q, fault_d;
  logic [DEB_W-1:0]   deb_cnt_q   [4:1];
  logic [DEB_W-1:0]   deb_cnt_d   [4:1];
  logic [STUCK_W-1:0] stuck_cnt_q [4:1];
  logic [STUCK_W-1:0] stuck_cnt_d [4:1];

  function automatic logic [STUCK_W-1:0] sat_inc(input logic [STUCK_W-1:0] v);
    return (v == STUCK_MAX) ? v : v + STUCK_W'(1);
  endfunction

  always_comb begin
    sr_d    = sr_q;
    rise_d  = '0;
    fault_d = fault_q;
    for (int i = 1; i <= 4; i++) begin
      deb_cnt_d[i]   = '0;
      stuck_cnt_d[i] = '0;
      // A differing level must persist DEB_CYCLES synchronised cycles before SR follows
      if (s2_q[i] != sr_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) sr_d[i] = s2_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
      end
      rise_d[i] = sr_d[i] & ~sr_q[i];
      if (FAULT_CLR) begin
        fault_d[i] = 1'b0;
      end else begin
        if (sr_q[i]) stuck_cnt_d[i] = sat_inc(stuck_cnt_q[i]);
        if (stuck_cnt_d[i] == STUCK_MAX) fault_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (RESET) begin
      s1_q    <= '0;
      s2_q    <= '0;
      sr_q    <= '0;
      rise_q  <= '0;
      fault_q <= '0;
      for (int i = 1; i <= 4; i++) begin
        deb_cnt_q[i]   <= '0;
        stuck_cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= RAW;
      s2_q    <= s1_q;
      sr_q    <= sr_d;
      rise_q  <= rise_d;
      fault_q <= fault_d;
      for (int i = 1; i <= 4; i++) begin
        deb_cnt_q[i]   <= deb_cnt_d[i];
        stuck_cnt_q[i] <= stuck_cnt_d[i];
      end
    end
  end

  assign SR      = sr_q;
  assign SR_RISE = rise_q;
  assign FAULT   = fault_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: stimulus queues timestamped output
// snapshots; a monitor pops one whenever any output changes and compares it.
module tb_sensor_conditioner;

  logic       Clock = 1'b0;
  logic       RESET;
  logic [4:1] RAW;
  logic       FAULT_CLR;
  logic [4:1] SR, SR_RISE, FAULT;

  sensor_conditioner #(
    .DEB_CYCLES(4), .DEB_W(3), .STUCK_CYCLES(16), .STUCK_W(5)
  ) dut (
    .Clock(Clock), .RESET(RESET), .RAW(RAW), .FAULT_CLR(FAULT_CLR),
    .SR(SR), .SR_RISE(SR_RISE), .FAULT(FAULT)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    int          cyc;
    logic [11:0] val;
  } exp_t;

  exp_t        q[$];
  int          edge_n = 0;
  int          n_vec  = 0;
  int          n_err  = 0;
  bit          mon_en = 1'b0;
  logic [11:0] prev   = '0;

  always @(posedge Clock) edge_n <= edge_n + 1;

  function automatic void push(int c, logic [4:1] sr, logic [4:1] rs, logic [4:1] ft);
    exp_t e;
    e.cyc = c;
    e.val = {sr, rs, ft};
    q.push_back(e);
  endfunction

  // Monitor: every output change is one presented event.
  always @(negedge Clock) begin
    logic [11:0] cur;
    exp_t        e;
    if (mon_en) begin
      cur = {SR, SR_RISE, FAULT};
      if (cur !== prev) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: got edge=%0d SR=%b RISE=%b FAULT=%b, required no change",
                   edge_n, cur[11:8], cur[7:4], cur[3:0]);
        end else begin
          e = q.pop_front();
          if (e.cyc != edge_n || e.val !== cur) begin
            n_err++;
            $display("FAIL event: got edge=%0d SR=%b RISE=%b FAULT=%b, required edge=%0d SR=%b RISE=%b FAULT=%b",
                     edge_n, cur[11:8], cur[7:4], cur[3:0],
                     e.cyc, e.val[11:8], e.val[7:4], e.val[3:0]);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic at(int t);
    while (edge_n < t) @(negedge Clock);
  endtask

  initial begin
    RESET     = 1'b1;
    RAW       = 4'b1111;
    FAULT_CLR = 1'b0;
    @(negedge Clock);
    RESET = 1'b0;
    n_vec++;
    if ({SR, SR_RISE, FAULT} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_state: got %b, required 000000000000", {SR, SR_RISE, FAULT});
    end
    mon_en = 1'b1;

    // Reset release with all contacts closed, then open again
    push(7,  4'b1111, 4'b1111, 4'b0000);
    push(8,  4'b1111, 4'b0000, 4'b0000);
    push(14, 4'b0000, 4'b0000, 4'b0000);
    at(8);  RAW = 4'b0000;

    // Reset mid-debounce discards the partial count
    push(30, 4'b0001, 4'b0001, 4'b0000);
    push(31, 4'b0001, 4'b0000, 4'b0000);
    push(38, 4'b0000, 4'b0000, 4'b0000);
    at(20); RAW = 4'b0001;
    at(23); RESET = 1'b1;
    at(24); RESET = 1'b0;
    at(32); RAW = 4'b0000;

    // Glitch of 3 cycles rejected; 4-cycle pulse accepted
    at(40); RAW = 4'b0010;
    at(43); RAW = 4'b0000;
    push(56, 4'b0010, 4'b0010, 4'b0000);
    push(57, 4'b0010, 4'b0000, 4'b0000);
    push(60, 4'b0000, 4'b0000, 4'b0000);
    at(50); RAW = 4'b0010;
    at(54); RAW = 4'b0000;

    // Bounce on channel 1
    push(80, 4'b0001, 4'b0001, 4'b0000);
    push(81, 4'b0001, 4'b0000, 4'b0000);
    push(88, 4'b0000, 4'b0000, 4'b0000);
    at(70); RAW = 4'b0001;
    at(71); RAW = 4'b0000;
    at(72); RAW = 4'b0001;
    at(73); RAW = 4'b0000;
    at(74); RAW = 4'b0001;
    at(82); RAW = 4'b0000;

    // Stuck fault on channel 4, sticky after release
    push(96,  4'b1000, 4'b1000, 4'b0000);
    push(97,  4'b1000, 4'b0000, 4'b0000);
    push(112, 4'b1000, 4'b0000, 4'b1000);
    push(121, 4'b0000, 4'b0000, 4'b1000);
    at(90);  RAW = 4'b1000;
    at(115); RAW = 4'b0000;

    // Clear racing channel 3 reaching the limit
    push(136, 4'b0100, 4'b0100, 4'b1000);
    push(137, 4'b0100, 4'b0000, 4'b1000);
    push(152, 4'b0100, 4'b0000, 4'b0000);
    push(168, 4'b0100, 4'b0000, 4'b0100);
    push(176, 4'b0000, 4'b0000, 4'b0100);
    push(181, 4'b0000, 4'b0000, 4'b0000);
    at(130); RAW = 4'b0100;
    at(151); FAULT_CLR = 1'b1;
    at(152); FAULT_CLR = 1'b0;
    at(170); RAW = 4'b0000;
    at(180); FAULT_CLR = 1'b1;
    at(181); FAULT_CLR = 1'b0;

    // Channel independence with skewed timing
    push(196, 4'b0001, 4'b0001, 4'b0000);
    push(197, 4'b0001, 4'b0000, 4'b0000);
    push(198, 4'b0101, 4'b0100, 4'b0000);
    push(199, 4'b0101, 4'b0000, 4'b0000);
    push(202, 4'b1101, 4'b1000, 4'b0000);
    push(203, 4'b1101, 4'b0000, 4'b0000);
    push(204, 4'b1010, 4'b0010, 4'b0000);
    push(205, 4'b1010, 4'b0000, 4'b0000);
    push(212, 4'b0000, 4'b0000, 4'b0000);
    at(190); RAW = 4'b0001;
    at(192); RAW = 4'b0101;
    at(196); RAW = 4'b1101;
    at(198); RAW = 4'b1010;
    at(206); RAW = 4'b0000;

    at(240);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL missing_events: got %0d events never seen, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
- Upstream stage of the train-control state machine.
- Takes four raw, asynchronous track-sensor contacts, synchronises and debounces them, and drives the clean SR[4:1] levels the controller consumes.
- Also emits single-cycle rising-edge pulses and a sticky per-sensor stuck-active fault flag for supervision logic.

Parameters:
- DEB_CYCLES, 4: consecutive synchronised cycles a new level must persist before SR follows (legal range >= 1).
- DEB_W, 3: debounce counter width; must satisfy 2^DEB_W > DEB_CYCLES.
- STUCK_CYCLES, 1000: cycles SR[i] may stay high before FAULT[i] sets (legal range >= 1).
- STUCK_W, 10: stuck counter width; must satisfy 2^STUCK_W > STUCK_CYCLES.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset; dominates all other inputs.
- RAW  input  4 [4:1]  raw sensor contacts; asynchronous; may bounce.
- FAULT_CLR  input  1  synchronous clear of all FAULT bits and stuck counters.
- SR  output  4 [4:1]  debounced sensor levels; registered; feeds the controller.
- SR_RISE  output  4 [4:1]  one-cycle pulse in the first cycle SR[i] is 1 after being 0; registered.
- FAULT  output  4 [4:1]  sticky stuck-active flag per sensor; registered.

Behaviour:
- Reset
  - RESET=1 at a rising edge clears every flop: sync stages, debounce counters, stuck counters, SR, SR_RISE and FAULT.
  - All outputs read 0 in the cycle after the reset edge.
  - Reset asserted mid-debounce discards the partial count.
- The four channels are independent and identical; no cross-channel logic.
- Synchroniser: two flops per channel, RAW[i] -> s1[i] -> s2[i]. Only s2 is used downstream.
- Debounce, per channel, evaluated at each edge:
  - s2[i]==SR[i]: deb_cnt[i] <= 0.
  - s2[i]!=SR[i] and deb_cnt[i] < DEB_CYCLES-1: deb_cnt[i] <= deb_cnt[i]+1.
  - s2[i]!=SR[i] and deb_cnt[i]==DEB_CYCLES-1: SR[i] <= s2[i], deb_cnt[i] <= 0.
  - Latency: RAW stable from sampling edge E0 gives SR change at edge E0+DEB_CYCLES+1.
  - Any reversion of s2 before the count completes clears the counter, so no SR change occurs.
  - A glitch shorter than DEB_CYCLES synchronised cycles never reaches SR.
- SR_RISE[i]
  - Set to 1 on the same edge SR[i] transitions 0->1; 0 on every other edge.
  - Never asserted for two consecutive cycles.
  - Not asserted on a 1->0 transition.
- Stuck detector, per channel:
  - SR[i]==0: stuck_cnt[i] <= 0.
  - SR[i]==1: stuck_cnt[i] increments, saturating at STUCK_CYCLES.
  - On the edge stuck_cnt[i] reaches STUCK_CYCLES, FAULT[i] <= 1.
  - FAULT[i] stays 1 after SR[i] falls, until RESET or FAULT_CLR.
- FAULT_CLR=1 at an edge: FAULT <= 0 and all stuck_cnt <= 0.
  - Any SR[i] still high restarts counting from 0 and re-faults STUCK_CYCLES edges later.
  - If FAULT_CLR coincides with the edge a counter would reach STUCK_CYCLES, the clear wins; that counter goes to 0.
- SR continues to track its input while FAULT[i]=1. Fault policy belongs to the consumer.
- Priority at any edge: RESET > FAULT_CLR > normal update.
- No combinational path from any input to any output.

Test Plan:
- Reset: RAW=4'b1111 held, RESET pulsed 1 for 1 cycle then 0 -> SR, SR_RISE, FAULT all 0 the cycle after reset. With DEB_CYCLES=4, SR=4'b1111 and SR_RISE=4'b1111 for exactly one cycle at the 5th edge after the first post-reset sampling edge.
- Glitch reject: RAW[2] high for 3 cycles then low, DEB_CYCLES=4 -> SR[2] and SR_RISE[2] stay 0 throughout. Repeat with a 4-cycle pulse -> SR[2] rises, then falls DEB_CYCLES+1 edges after RAW returns low.
- Bounce: RAW[1] toggles 1,0,1,0,1 on consecutive cycles then holds 1 -> exactly one SR_RISE[1] pulse; SR[1] rises DEB_CYCLES+1 edges after the final stable sample.
- Stuck fault: STUCK_CYCLES=16, RAW[4] held high -> FAULT[4]=1 exactly 16 edges after SR[4] rises. RAW[4] then low -> FAULT[4] remains 1 while SR[4] returns to 0.
- Fault clear race: FAULT_CLR asserted on the edge stuck_cnt[3] would hit 16 -> FAULT[3] stays 0, counter restarts, FAULT[3] sets 16 edges later if RAW[3] stays high.
- Independence: RAW=4'b0101 then 4'b1010 with skewed timing -> each SR bit follows its own latency; SR_RISE bits fire only in their own channel's rising cycle.
